// File: rtl/change_dispenser.sv
// change_dispenser: pays a cents amount out as a paced train of single-coin
// pulses (quarter, dime, nickle), largest coin first. Every output is a flop
// loaded from the next-state values, so no output follows an input
// combinationally.
module change_dispenser #(
  parameter int PULSE_LEN = 1,
  parameter int GAP_LEN   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] amount,
  output logic       quarter,
  output logic       dime,
  output logic       nickle,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [5:0] remaining
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    COIN_N = 2'd0,
    COIN_D = 2'd1,
    COIN_Q = 2'd2
  } coin_t;

  // One counter serves both the pulse and the gap phases.
  localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_r, state_nxt_s;
  coin_t            coin_r, coin_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [5:0]       rem_nxt_s;
  logic             err_nxt_s;

  // Greedy choice: the largest coin that still fits in the outstanding amount.
  function automatic coin_t pick_coin(input logic [5:0] cents);
    if (cents >= 6'd25) begin
      return COIN_Q;
    end else if (cents >= 6'd10) begin
      return COIN_D;
    end else begin
      return COIN_N;
    end
  endfunction

  // Value in cents of a latched coin.
  function automatic logic [5:0] coin_value(input coin_t coin);
    case (coin)
      COIN_Q:  return 6'd25;
      COIN_D:  return 6'd10;
      COIN_N:  return 6'd5;
      default: return 6'd5;
    endcase
  endfunction

  // Next-state, coin selection, pacing counter and remaining-amount update.
  always_comb begin
    state_nxt_s = state_r;
    coin_nxt_s  = coin_r;
    cnt_nxt_s   = cnt_r;
    rem_nxt_s   = remaining;
    err_nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if ((amount % 6'd5) != 6'd0) begin
            // Reject: remaining left untouched, stay idle.
            err_nxt_s = 1'b1;
          end else if (amount == 6'd0) begin
            rem_nxt_s   = 6'd0;
            state_nxt_s = DONE;
          end else begin
            rem_nxt_s   = amount;
            coin_nxt_s  = pick_coin(amount);
            cnt_nxt_s   = CNT_ZERO;
            state_nxt_s = PULSE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PULSE: begin
        if (cnt_r == PULSE_LAST) begin
          rem_nxt_s   = remaining - coin_value(coin_r);
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = GAP;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_r == GAP_LAST) begin
          cnt_nxt_s = CNT_ZERO;
          if (remaining == 6'd0) begin
            state_nxt_s = DONE;
          end else begin
            coin_nxt_s  = pick_coin(remaining);
            state_nxt_s = PULSE;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Control state: FSM state, latched coin and pacing counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      coin_r  <= COIN_N;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      coin_r  <= coin_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Output flops, decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quarter   <= 1'b0;
      dime      <= 1'b0;
      nickle    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      remaining <= 6'd0;
    end else begin
      quarter   <= (state_nxt_s == PULSE) && (coin_nxt_s == COIN_Q);
      dime      <= (state_nxt_s == PULSE) && (coin_nxt_s == COIN_D);
      nickle    <= (state_nxt_s == PULSE) && (coin_nxt_s == COIN_N);
      busy      <= (state_nxt_s != IDLE);
      done      <= (state_nxt_s == DONE);
      err       <= err_nxt_s;
      remaining <= rem_nxt_s;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser. Two instances: default pacing
// (P=G=1) and slow pacing (P=3, G=2). Expected waveforms come from the
// greedy coin counts and the cycle-timing formulas, computed arithmetically.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start1 = 1'b0, start2 = 1'b0;
  logic [5:0] amount1 = 6'd0, amount2 = 6'd0;
  logic       q1, d1, n1, busy1, done1, err1;
  logic       q2, d2, n2, busy2, done2, err2;
  logic [5:0] rem1, rem2;
  logic [11:0] obs1, obs2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  change_dispenser dut1 (
    .clk(clk), .reset(reset), .start(start1), .amount(amount1),
    .quarter(q1), .dime(d1), .nickle(n1), .busy(busy1), .done(done1),
    .err(err1), .remaining(rem1)
  );

  change_dispenser #(.PULSE_LEN(3), .GAP_LEN(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .amount(amount2),
    .quarter(q2), .dime(d2), .nickle(n2), .busy(busy2), .done(done2),
    .err(err2), .remaining(rem2)
  );

  // Observation vectors: {quarter, dime, nickle, busy, done, err, remaining}.
  assign obs1 = {q1, d1, n1, busy1, done1, err1, rem1};
  assign obs2 = {q2, d2, n2, busy2, done2, err2, rem2};

  typedef struct {
    int amt;
    int nq;
    int nd;
    int nn;
    int ndone;
    int nerr;
  } vec_t;

  // Greedy coin list from plain division.
  function automatic int coin_list(input int amt, output int c[4]);
    int nq, nd, nn, k;
    nq = amt / 25;
    nd = (amt % 25) / 10;
    nn = ((amt % 25) % 10) / 5;
    k = 0;
    for (int i = 0; i < 4; i++) c[i] = 0;
    for (int i = 0; i < nq; i++) begin c[k] = 25; k++; end
    for (int i = 0; i < nd; i++) begin c[k] = 10; k++; end
    for (int i = 0; i < nn; i++) begin c[k] = 5;  k++; end
    return k;
  endfunction

  // Expected outputs in cycle k+t for a request of amt with pacing p/g.
  function automatic logic [11:0] model_out(input int amt, input int p, input int g, input int t);
    int c[4];
    int n, per, rem, i;
    logic q, d, nk, bz, dn, er;
    q = 1'b0; d = 1'b0; nk = 1'b0; bz = 1'b0; dn = 1'b0; er = 1'b0;
    rem = 0;
    per = p + g;
    if (amt % 5 != 0) begin
      er = (t == 1);
    end else begin
      n = coin_list(amt, c);
      if (t == n * per + 1) begin
        bz = 1'b1;
        dn = 1'b1;
      end else if (t <= n * per) begin
        bz = 1'b1;
        i = (t - 1) / per;
        if ((t - 1) % per < p) begin
          q  = (c[i] == 25);
          d  = (c[i] == 10);
          nk = (c[i] == 5);
        end
        rem = amt;
        for (int j = 0; j < n; j++)
          if (j * per + p < t) rem = rem - c[j];
      end
    end
    return {q, d, nk, bz, dn, er, 6'(rem)};
  endfunction

  function automatic int total_cycles(input int amt, input int p, input int g);
    int c[4];
    if (amt % 5 != 0) return 1;
    return coin_list(amt, c) * (p + g) + 1;
  endfunction

  task automatic check_vec(input string name, input int t, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got qdn/busy/done/err/rem=%b expected=%b", name, t, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Issue one request and compare every cycle through the return to IDLE.
  // Optionally pulse a second start (lock_amt) during cycle lock_t.
  task automatic run_check(input int which, input int amt, input int lock_t, input int lock_amt,
                           input string name, output int nq, output int nd, output int nn,
                           output int ndone, output int nerr);
    int p, g, tot;
    logic [11:0] got, prev;
    p = (which == 1) ? 1 : 3;
    g = (which == 1) ? 1 : 2;
    tot = total_cycles(amt, p, g);
    nq = 0; nd = 0; nn = 0; ndone = 0; nerr = 0;
    prev = 12'd0;
    @(negedge clk);
    if (which == 1) begin start1 = 1'b1; amount1 = 6'(amt); end
    else            begin start2 = 1'b1; amount2 = 6'(amt); end
    for (int t = 1; t <= tot + 1; t++) begin
      @(negedge clk);
      got = (which == 1) ? obs1 : obs2;
      check_vec(name, t, got, model_out(amt, p, g, t));
      if (got[11] && !prev[11]) nq++;
      if (got[10] && !prev[10]) nd++;
      if (got[9]  && !prev[9])  nn++;
      if (got[7]) ndone++;
      if (got[6]) nerr++;
      prev = got;
      if (which == 1) begin
        start1 = (t == lock_t);
        if (t == lock_t) amount1 = 6'(lock_amt);
      end else begin
        start2 = (t == lock_t);
        if (t == lock_t) amount2 = 6'(lock_amt);
      end
    end
  endtask

  initial begin
    vec_t vecs[12];
    int nq, nd, nn, ndone, nerr, amt, which;

    vecs[0]  = '{60, 2, 1, 0, 1, 0};
    vecs[1]  = '{55, 2, 0, 1, 1, 0};
    vecs[2]  = '{45, 1, 2, 0, 1, 0};
    vecs[3]  = '{40, 1, 1, 1, 1, 0};
    vecs[4]  = '{35, 1, 1, 0, 1, 0};
    vecs[5]  = '{30, 1, 0, 1, 1, 0};
    vecs[6]  = '{20, 0, 2, 0, 1, 0};
    vecs[7]  = '{15, 0, 1, 1, 1, 0};
    vecs[8]  = '{0,  0, 0, 0, 1, 0};
    vecs[9]  = '{7,  0, 0, 0, 0, 1};
    vecs[10] = '{5,  0, 0, 1, 1, 0};
    vecs[11] = '{25, 1, 0, 0, 1, 0};

    // Reset values
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_vec("reset_dut1", 0, obs1, 12'd0);
    check_vec("reset_dut2", 0, obs2, 12'd0);
    run_check(1, 15, 0, 0, "after_reset_15", nq, nd, nn, ndone, nerr);

    // Table of greedy payouts with coin/done/err counts
    foreach (vecs[i]) begin
      run_check(1, vecs[i].amt, 0, 0, $sformatf("table_amt%0d", vecs[i].amt), nq, nd, nn, ndone, nerr);
      check_int($sformatf("table_q_amt%0d", vecs[i].amt), nq, vecs[i].nq);
      check_int($sformatf("table_d_amt%0d", vecs[i].amt), nd, vecs[i].nd);
      check_int($sformatf("table_n_amt%0d", vecs[i].amt), nn, vecs[i].nn);
      check_int($sformatf("table_done_amt%0d", vecs[i].amt), ndone, vecs[i].ndone);
      check_int($sformatf("table_err_amt%0d", vecs[i].amt), nerr, vecs[i].nerr);
    end

    // Busy lockout: second start during payout is ignored
    run_check(1, 40, 2, 25, "lockout_40", nq, nd, nn, ndone, nerr);
    check_int("lockout_coins", nq * 100 + nd * 10 + nn, 111);
    check_int("lockout_done", ndone, 1);

    // Reset mid-operation during the first dime of 45
    @(negedge clk);
    start1 = 1'b1;
    amount1 = 6'd45;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      start1 = 1'b0;
      check_vec("midreset_pre", t, obs1, model_out(45, 1, 1, t));
    end
    #2 reset = 1'b0;
    #1 check_vec("midreset_async", 3, obs1, 12'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_check(1, 10, 0, 0, "after_midreset_10", nq, nd, nn, ndone, nerr);
    check_int("after_midreset_dimes", nd, 1);

    // Pacing parameters P=3, G=2
    run_check(2, 30, 0, 0, "pacing_30", nq, nd, nn, ndone, nerr);
    check_int("pacing_coins", nq * 100 + nd * 10 + nn, 101);

    // Randomized requests on both instances
    for (int r = 0; r < 30; r++) begin
      amt = $urandom_range(0, 63);
      if (r % 2 == 0) amt = (amt / 5) * 5;
      which = $urandom_range(1, 2);
      run_check(which, amt, 0, 0, $sformatf("rand_dut%0d_amt%0d", which, amt), nq, nd, nn, ndone, nerr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin-return block on the output side of the vending machine. It accepts a change amount in cents and pays it out as a paced train of single-coin pulses on `quarter`, `dime` and `nickle`. Those are the same coin lines and the same 6-bit cents encoding that the vending machine consumes on its input side. Payout is greedy (largest coin first), paced by programmable pulse and gap lengths, and signals completion with a one-cycle `done`.

## Interface
- `PULSE_LEN`, default 1: cycles each coin line is held high per coin (≥1).
- `GAP_LEN`, default 1: cycles all coin lines are held low after each coin (≥1).

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; sampled only in IDLE.
- `amount`  in  6  change to pay out in cents, 0..63; must be a multiple of 5.
- `quarter`  out  1  one pulse per 25¢ coin dispensed.
- `dime`  out  1  one pulse per 10¢ coin dispensed.
- `nickle`  out  1  one pulse per 5¢ coin dispensed.
- `busy`  out  1  high while a payout is in progress, through the DONE cycle.
- `done`  out  1  one-cycle strobe when the payout completes.
- `err`  out  1  one-cycle strobe when a request is rejected.
- `remaining`  out  6  cents still to dispense (registered).

## Operation
- **Reset** (`reset`=0, asynchronous):
  - State is IDLE.
  - All outputs are 0, `remaining`=0, internal counters are 0.
  - Applies immediately, including mid-payout. A partially dispensed amount is abandoned and never resumed.
- **All outputs are registered.** No output depends combinationally on any input.
- **States:** IDLE, PULSE, GAP, DONE.
- **IDLE:**
  - `busy`=0 and all coin lines are 0.
  - On `start`=1:
    - `amount` mod 5 ≠ 0: `err`=1 for the next cycle only, then stay in IDLE. `remaining` is unchanged and no coins are issued.
    - `amount`=0: go to DONE. No coins are issued.
    - Otherwise: load `remaining`=`amount`, select a coin, go to PULSE.
- **Coin selection** is evaluated on entry to PULSE and latched for the whole pulse:
  - `remaining` ≥ 25: quarter.
  - else `remaining` ≥ 10: dime.
  - else: nickle.
- **PULSE:**
  - The selected coin line is high and the other two are low.
  - A counter runs for PULSE_LEN cycles.
  - On the last cycle, `remaining` is decremented by the coin value (25/10/5) in 6-bit unsigned arithmetic. Underflow cannot occur for valid amounts.
  - Next state is GAP.
- **GAP:**
  - All coin lines are low for GAP_LEN cycles.
  - Then go to DONE if `remaining`=0, else select the next coin and go to PULSE.
- **DONE:** `done`=1 and `busy`=1 for exactly one cycle, then IDLE.
- **`start` while busy** (PULSE/GAP/DONE) is ignored entirely. It is not queued, and `amount` is not re-sampled.
- **Only one coin line is ever high at a time.** Each coin is exactly PULSE_LEN cycles high followed by at least GAP_LEN cycles low, so a downstream edge counter sees one rising edge per coin.
- **Greedy examples:**
  - 60 → Q,Q,D
  - 55 → Q,Q,N
  - 45 → Q,D,D
  - 40 → Q,D,N
  - 35 → Q,D
  - 30 → Q,N
  - 20 → D,D
  - 15 → D,N

## Timing
- Let edge k be the edge where `start` is sampled in IDLE. With N coins, P=PULSE_LEN and G=GAP_LEN:
  - `busy` rises at k+1.
  - The first coin line rises at k+1.
  - Coin i (0-based) is high during cycles k+1+i(P+G) … k+i(P+G)+P.
  - `done` is high during cycle k+1+N(P+G).
  - The block is back in IDLE, able to accept `start`, at k+2+N(P+G).
- `amount`=0: `done` and `busy` are high in cycle k+1 only.
- Invalid amount: `err` is high in cycle k+1 only, and `busy` stays 0.
- Back-to-back requests: the minimum spacing between accepted `start` strobes is N(P+G)+2 cycles.
- `remaining` updates on the last PULSE cycle of each coin and reads 0 in the DONE cycle.

## Test plan
- **Reset values:** hold `reset`=0 for 2 cycles then release → all outputs are 0 and `remaining`=0. Then `start` with `amount`=15 (P=G=1) → `dime` high at k+1, `nickle` high at k+3, `done` at k+5, `busy` high k+1..k+5.
- **Two quarters and a dime:** `amount`=60 → exactly Q,Q,D pulses at k+1, k+3, k+5; `remaining` steps 35, 10, 0; `done` at k+7; never two coin lines high at once.
- **Zero and invalid amounts:**
  - `amount`=0 → `done`=1 at k+1 with no coin pulses.
  - `amount`=7 → `err`=1 at k+1 only, `busy` stays 0, no coins, `done` never asserts.
- **Busy lockout:** `amount`=40, then `start` with `amount`=25 at k+2 → the second request is ignored; the output is Q,D,N only; `done` fires once at k+7.
- **Reset mid-operation:** `amount`=45, assert `reset`=0 asynchronously mid-pulse during the first dime → all outputs drop to 0 immediately. After release, `start` with `amount`=10 → a single dime, `done` at k+3.
- **Pacing parameters:** with PULSE_LEN=3 and GAP_LEN=2, `amount`=30 → `quarter` high k+1..k+3, `nickle` high k+6..k+8, `done` at k+11.
